counter_load_param: RTL and testbench
=====================================

Name: counter_load_param

Overview:
- Parametrised loadable counter. Counts up or down.
- Has a reload register and three terminal-count modes: reload-wrap, saturate and one-shot.
- Gives a terminal-count pulse and a sticky done flag.
- Used as a general timer/sequencer counter in the RTL practice library. It replaces the fixed 4-bit up-only load counter.

Parameters:
- WIDTH, 4, counter, load value and reload register width in bits (WIDTH >= 2).
- RESET_VAL, 0, value of count and the reload register after reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low. Assertion immediately forces all state to reset values. Deassertion is assumed synchronous to clk.
- en  input  1  count enable; advances the counter when high.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value loaded into count and the reload register.
- up_dn  input  1  direction: 1 = count up, 0 = count down.
- mode  input  2  00 reload-wrap, 01 saturate, 10 one-shot, 11 = same as 00.
- count  output  WIDTH  current count value (registered).
- tc  output  1  one-cycle terminal-count pulse (registered).
- done  output  1  sticky one-shot completion flag (registered).

Behaviour:
- Reset (rst low):
  - count = RESET_VAL, reload_r = RESET_VAL, tc = 0, done = 0.
  - Applies at any time, including mid-count. Inputs are ignored while rst is low.
- Terminal condition (combinational, internal): term = (up_dn && count == all ones) || (!up_dn && count == 0).
- Priority at each rising edge: load > en > hold.
- load = 1 (en ignored):
  - count <= load_val, reload_r <= load_val, done <= 0, tc <= 0.
- load = 0, en = 1, term = 0:
  - count <= count + 1 if up_dn, otherwise count - 1. Arithmetic is modulo 2^WIDTH.
  - tc <= 0.
- load = 0, en = 1, term = 1: tc <= 1, and count depends on mode.
  - Mode 00/11: count <= reload_r.
  - Mode 01: count holds. tc pulses on every enabled cycle spent at the terminal value.
  - Mode 10 with done = 0: count holds and done <= 1. tc fires once only.
  - Mode 10 with done = 1: count holds and tc <= 0. The counter is frozen until load. en has no effect.
- load = 0, en = 0: count, done and reload_r hold; tc <= 0.
- Latency:
  - count reflects load_val, or the next value, one clock after the qualifying edge.
  - tc and done are asserted in the same cycle that count shows the post-terminal value.
- Edge cases:
  - Changing up_dn mid-count takes effect on the next enabled edge. term is evaluated against the current direction.
  - Mode changes are sampled every edge. Leaving mode 10 while done = 1 leaves done set; only load or reset clears it.
  - reload_r equal to the terminal value in mode 00 gives tc on every enabled cycle with count constant. This is legal.
  - load and en asserted together: load wins and no count step occurs.
- No combinational path from inputs to outputs.

Test Plan:
- Reset mid-operation:
  - Count running at 9, assert rst low asynchronously between edges.
  - Required: count = RESET_VAL, tc = 0, done = 0 immediately, without waiting for an edge.
  - Release, then en = 1, up: count goes 0,1,2.
- Reload-wrap up:
  - WIDTH = 4, load 4'd13, mode 00, up, en = 1.
  - Required count: 13,14,15,13,14,15.
  - tc high only in the cycles where count shows 13 after 15.
- Saturate down:
  - Load 4'd2, mode 01, down, en = 1 for 5 cycles.
  - Required count: 2,1,0,0,0.
  - tc = 1 on each of the three enabled cycles at 0.
- One-shot:
  - Load 4'd14, mode 10, up, en = 1.
  - Required count: 14,15,15,15. done rises when 15 is first held. tc is high for exactly one cycle.
  - Then load 4'd3: done = 0 and count = 3 next cycle.
- Priority and hold:
  - At count = 5, assert load = 1 and en = 1 with load_val = 4'd10: next count = 10, no increment.
  - Then en = 0 for 3 cycles: count stays 10, tc = 0.
- Parameter sweep:
  - WIDTH = 8, RESET_VAL = 8'h80, mode 00, up, without any load.
  - Required count: 0x80 ... 0xFF, then 0x80, with tc at that wrap.

Source files
------------

// File: rtl/counter_load_param.sv
// Loadable up/down counter with a reload register and three terminal-count modes:
// reload-wrap, saturate and one-shot. It provides a one-cycle tc pulse and a sticky done flag.
module counter_load_param #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [1:0]       MODE_SAT = 2'b01;
  localparam logic [1:0]       MODE_ONE = 2'b10;

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             term;

  // Terminal value depends on the direction currently applied, not the last one used.
  assign term = up_dn ? (count_q == ALL_ONES) : (count_q == '0);

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = done_q;
    tc_d     = 1'b0;
    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      done_d   = 1'b0;
    end else if (en) begin
      if (!term) begin
        count_d = up_dn ? (count_q + ONE) : (count_q - ONE);
      end else begin
        unique case (mode)
          MODE_SAT: tc_d = 1'b1;
          MODE_ONE: begin
            // After the first completion the counter stays frozen until it is loaded again.
            if (!done_q) begin
              tc_d   = 1'b1;
              done_d = 1'b1;
            end
          end
          default: begin
            count_d = reload_q;
            tc_d    = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= RESET_VAL;
      reload_q <= RESET_VAL;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      done_q   <= done_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign done  = done_q;

endmodule

// File: tb/tb_counter_load_param.sv
// Directed, table-driven bench for counter_load_param. It uses a 4-bit instance for the
// mode and priority vectors and an 8-bit instance (RESET_VAL 0x80) for the free-run wrap sweep.
module tb_counter_load_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en, load, up_dn;
  logic [1:0] mode;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       tc, done;

  logic       en_b, load_b, up_dn_b;
  logic [1:0] mode_b;
  logic [7:0] load_val_b;
  logic [7:0] count_b;
  logic       tc_b, done_b;

  counter_load_param #(.WIDTH(4), .RESET_VAL(4'd0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .up_dn(up_dn), .mode(mode), .count(count), .tc(tc), .done(done)
  );

  counter_load_param #(.WIDTH(8), .RESET_VAL(8'h80)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .load(load_b), .load_val(load_val_b),
    .up_dn(up_dn_b), .mode(mode_b), .count(count_b), .tc(tc_b), .done(done_b)
  );

  typedef struct {
    logic       load;
    logic       en;
    logic       up_dn;
    logic [1:0] mode;
    logic [3:0] load_val;
    logic [3:0] e_count;
    logic       e_tc;
    logic       e_done;
    string      name;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic add(input logic ld, input logic e, input logic ud, input logic [1:0] m,
                     input logic [3:0] lv, input logic [3:0] ec, input logic et,
                     input logic ed, input string nm);
    vec_t v;
    v.load = ld; v.en = e; v.up_dn = ud; v.mode = m; v.load_val = lv;
    v.e_count = ec; v.e_tc = et; v.e_done = ed; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string nm, input logic [3:0] ec, input logic et, input logic ed);
    chk({nm, ".count"}, 32'(count), 32'(ec));
    chk({nm, ".tc"},    32'(tc),    32'(et));
    chk({nm, ".done"},  32'(done),  32'(ed));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; up_dn = 1'b1; mode = 2'b00; load_val = '0;
    en_b = 1'b0; load_b = 1'b0; up_dn_b = 1'b1; mode_b = 2'b00; load_val_b = '0;

    // reload-wrap up
    add(1, 0, 1, 2'b00, 4'd13, 4'd13, 0, 0, "wrap_load");
    add(0, 1, 1, 2'b00, 4'd0,  4'd14, 0, 0, "wrap_14");
    add(0, 1, 1, 2'b00, 4'd0,  4'd15, 0, 0, "wrap_15");
    add(0, 1, 1, 2'b00, 4'd0,  4'd13, 1, 0, "wrap_13a");
    add(0, 1, 1, 2'b00, 4'd0,  4'd14, 0, 0, "wrap_14b");
    add(0, 1, 1, 2'b00, 4'd0,  4'd15, 0, 0, "wrap_15b");
    add(0, 1, 1, 2'b00, 4'd0,  4'd13, 1, 0, "wrap_13b");
    // saturate down
    add(1, 0, 0, 2'b01, 4'd2,  4'd2,  0, 0, "sat_load");
    add(0, 1, 0, 2'b01, 4'd0,  4'd1,  0, 0, "sat_1");
    add(0, 1, 0, 2'b01, 4'd0,  4'd0,  0, 0, "sat_0");
    add(0, 1, 0, 2'b01, 4'd0,  4'd0,  1, 0, "sat_hold1");
    add(0, 1, 0, 2'b01, 4'd0,  4'd0,  1, 0, "sat_hold2");
    add(0, 1, 0, 2'b01, 4'd0,  4'd0,  1, 0, "sat_hold3");
    add(0, 0, 0, 2'b01, 4'd0,  4'd0,  0, 0, "sat_idle");
    // one-shot, then leave mode 10 with done set, then load clears
    add(1, 0, 1, 2'b10, 4'd14, 4'd14, 0, 0, "os_load");
    add(0, 1, 1, 2'b10, 4'd0,  4'd15, 0, 0, "os_15");
    add(0, 1, 1, 2'b10, 4'd0,  4'd15, 1, 1, "os_done");
    add(0, 1, 1, 2'b10, 4'd0,  4'd15, 0, 1, "os_frozen1");
    add(0, 1, 1, 2'b10, 4'd0,  4'd15, 0, 1, "os_frozen2");
    add(0, 1, 1, 2'b00, 4'd0,  4'd14, 1, 1, "os_modechg");
    add(1, 0, 1, 2'b10, 4'd3,  4'd3,  0, 0, "os_reload");
    // priority and hold
    add(1, 0, 1, 2'b00, 4'd5,  4'd5,  0, 0, "pri_load5");
    add(1, 1, 1, 2'b00, 4'd10, 4'd10, 0, 0, "pri_load_en");
    add(0, 0, 1, 2'b00, 4'd0,  4'd10, 0, 0, "hold1");
    add(0, 0, 1, 2'b00, 4'd0,  4'd10, 0, 0, "hold2");
    add(0, 0, 1, 2'b00, 4'd0,  4'd10, 0, 0, "hold3");
    // reload equals terminal value
    add(1, 0, 1, 2'b00, 4'd15, 4'd15, 0, 0, "rterm_load");
    add(0, 1, 1, 2'b00, 4'd0,  4'd15, 1, 0, "rterm_1");
    add(0, 1, 1, 2'b00, 4'd0,  4'd15, 1, 0, "rterm_2");
    // direction change mid-count
    add(1, 0, 1, 2'b00, 4'd0,  4'd0,  0, 0, "dir_load");
    add(0, 1, 1, 2'b00, 4'd0,  4'd1,  0, 0, "dir_up");
    add(0, 1, 0, 2'b00, 4'd0,  4'd0,  0, 0, "dir_down");
    add(0, 1, 0, 2'b00, 4'd0,  4'd0,  1, 0, "dir_term");
    // mode 11 behaves as reload-wrap
    add(1, 0, 1, 2'b11, 4'd14, 4'd14, 0, 0, "m11_load");
    add(0, 1, 1, 2'b11, 4'd0,  4'd15, 0, 0, "m11_15");
    add(0, 1, 1, 2'b11, 4'd0,  4'd14, 1, 0, "m11_wrap");

    // reset state
    #2 rst = 1'b0;
    #1;
    chk_a("rst_async", 4'd0, 0, 0);
    tick();
    tick();
    chk_a("rst_state", 4'd0, 0, 0);
    chk("rst_b.count", 32'(count_b), 32'h80);
    rst = 1'b1;

    // run to 9, then reset asynchronously between edges
    en = 1'b1; up_dn = 1'b1; mode = 2'b00;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk($sformatf("run_%0d", i), 32'(count), 32'(i));
    end
    #3 rst = 1'b0;
    #1;
    chk_a("rst_mid", 4'd0, 0, 0);
    @(posedge clk);
    #1;
    chk("rst_held", 32'(count), 32'd0);
    rst = 1'b1;
    tick();
    chk("rel_1", 32'(count), 32'd1);
    tick();
    chk("rel_2", 32'(count), 32'd2);

    foreach (vecs[i]) begin
      load = vecs[i].load; en = vecs[i].en; up_dn = vecs[i].up_dn;
      mode = vecs[i].mode; load_val = vecs[i].load_val;
      tick();
      chk_a(vecs[i].name, vecs[i].e_count, vecs[i].e_tc, vecs[i].e_done);
    end
    load = 1'b0; en = 1'b0;

    // 8-bit free run from RESET_VAL 0x80 wraps back to the reset reload value
    chk("sw_start", 32'(count_b), 32'h80);
    en_b = 1'b1; up_dn_b = 1'b1; mode_b = 2'b00;
    for (int k = 1; k <= 128; k++) begin
      tick();
      if (k < 128) begin
        chk($sformatf("sw_cnt_%0d", k), 32'(count_b), 32'(8'h80 + k));
        chk($sformatf("sw_tc_%0d", k), 32'(tc_b), 32'd0);
      end else begin
        chk("sw_wrap_cnt", 32'(count_b), 32'h80);
        chk("sw_wrap_tc", 32'(tc_b), 32'd1);
        chk("sw_done", 32'(done_b), 32'd0);
      end
    end
    en_b = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
